// File: rtl/afifo_pkg.sv
// Shared definitions for the single-clock parametrised FIFO.
//   depth()        : number of words for a given address width
//   fifo_status_t  : flag bundle for monitors and scoreboards
//   pack_status()  : builds a fifo_status_t from the individual flags
package afifo_pkg;

   // Number of words addressed by an asize-bit pointer
   function automatic int unsigned depth(input int unsigned asize);
      return 32'(1) << asize;
   endfunction

   typedef struct packed {
      logic wfull;
      logic rempty;
      logic almost_full;
      logic almost_empty;
      logic overflow;
      logic underflow;
   } fifo_status_t;

   // Collects the FIFO flags into one struct for observation
   function automatic fifo_status_t pack_status(
      input logic wfull,
      input logic rempty,
      input logic almost_full,
      input logic almost_empty,
      input logic overflow,
      input logic underflow
   );
      fifo_status_t s;
      s.wfull        = wfull;
      s.rempty       = rempty;
      s.almost_full  = almost_full;
      s.almost_empty = almost_empty;
      s.overflow     = overflow;
      s.underflow    = underflow;
      return s;
   endfunction

endpackage

// File: rtl/afifo_sync_mem.sv
// Storage array for afifo_sync_param: DEPTH x DSIZE words.
//   wclk  : write clock
//   wen   : write enable, stores wdata at waddr on posedge wclk
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : asynchronous read data, mem[raddr]
// Contents are not reset.
module afifo_sync_mem
   import afifo_pkg::*;
#(
   parameter int unsigned DSIZE = 8,
   parameter int unsigned ASIZE = 4
) (
   input  logic             wclk,
   input  logic             wen,
   input  logic [ASIZE-1:0] waddr,
   input  logic [DSIZE-1:0] wdata,
   input  logic [ASIZE-1:0] raddr,
   output logic [DSIZE-1:0] rdata
);

   localparam int unsigned DEPTH = depth(ASIZE);

   logic [DSIZE-1:0] mem [DEPTH];

   // Synchronous write port
   always_ff @(posedge wclk) begin
      if (wen) begin
         mem[waddr] <= wdata;
      end
   end

   // Asynchronous read port
   assign rdata = mem[raddr];

endmodule

// File: rtl/afifo_sync_param.sv
// Single-clock parametrised FIFO with optional first-word-fall-through read.
//   clk, rst_n          : clock, synchronous active-low reset
//   winc, wdata, wfull  : write request, write data, full flag
//   rinc, rdata, rempty : read request (pop), read data, empty flag
//   count               : words stored (0..DEPTH)
//   almost_full         : count >= AFULL_THRESH
//   almost_empty        : count <= AEMPTY_THRESH
//   flush               : synchronous empty command
//   clr_err             : clears the sticky error flags
//   overflow, underflow : sticky rejected-write / rejected-read flags
// Parameters: DSIZE data width, ASIZE address width, FWFT read mode
// (0 registered read, 1 first-word-fall-through), almost thresholds.
module afifo_sync_param
   import afifo_pkg::*;
#(
   parameter int unsigned DSIZE         = 8,
   parameter int unsigned ASIZE         = 4,
   parameter int unsigned FWFT          = 0,
   parameter int unsigned AFULL_THRESH  = depth(ASIZE) - 2,
   parameter int unsigned AEMPTY_THRESH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             winc,
   input  logic [DSIZE-1:0] wdata,
   output logic             wfull,
   input  logic             rinc,
   output logic [DSIZE-1:0] rdata,
   output logic             rempty,
   output logic [ASIZE:0]   count,
   output logic             almost_full,
   output logic             almost_empty,
   input  logic             flush,
   input  logic             clr_err,
   output logic             overflow,
   output logic             underflow
);

   localparam int unsigned DEPTH = depth(ASIZE);
   localparam int unsigned CW    = ASIZE + 1;

   // Threshold ordering is fixed at build time
   if (!((AEMPTY_THRESH < AFULL_THRESH) && (AFULL_THRESH <= DEPTH))) begin : g_thresh_err
      $error("afifo_sync_param: need AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
   end

   logic [ASIZE-1:0] wptr;
   logic [ASIZE-1:0] rptr;
   logic [DSIZE-1:0] mem_rdata;
   logic             wr_ok;
   logic             rd_ok;
   logic             wr_rej;
   logic             rd_rej;

   // Flags decode the registered count, so they reflect pre-edge state
   assign wfull        = (count == CW'(DEPTH));
   assign rempty       = (count == '0);
   assign almost_full  = (32'(count) >= AFULL_THRESH);
   assign almost_empty = (32'(count) <= AEMPTY_THRESH);

   // Accept/reject decisions; flush suppresses both requests
   assign wr_ok  = winc && !wfull  && !flush;
   assign rd_ok  = rinc && !rempty && !flush;
   assign wr_rej = winc && wfull   && !flush;
   assign rd_rej = rinc && rempty  && !flush;

   // Storage; writes are gated by reset so a reset cycle stores nothing
   afifo_sync_mem #(
      .DSIZE (DSIZE),
      .ASIZE (ASIZE)
   ) u_mem (
      .wclk  (clk),
      .wen   (wr_ok && rst_n),
      .waddr (wptr),
      .wdata (wdata),
      .raddr (rptr),
      .rdata (mem_rdata)
   );

   // Pointers and occupancy
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_ok) begin
            wptr <= wptr + ASIZE'(1);
         end
         if (rd_ok) begin
            rptr <= rptr + ASIZE'(1);
         end
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky error flags; a new rejection wins over clr_err
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= wr_rej || (overflow  && !clr_err);
         underflow <= rd_rej || (underflow && !clr_err);
      end
   end

   // Output stage: registered read or fall-through head of queue
   if (FWFT == 0) begin : g_std
      logic [DSIZE-1:0] rdata_q;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            rdata_q <= '0;
         end else if (rd_ok) begin
            rdata_q <= mem_rdata;
         end
      end

      assign rdata = rdata_q;
   end else begin : g_fwft
      // Forced to zero while empty so the output is stable and reset-clean
      assign rdata = rempty ? '0 : mem_rdata;
   end

endmodule
